rtc_bus_scheduler: RTL

//  Shares the RTC parallel-bus write/clear unit and the RTC read unit between three requesters:

---
 rtl/rtc_bus_scheduler.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/rtc_bus_scheduler.sv
// Arbitrates the RTC write/clear unit and the RTC read unit over one shared parallel bus.
// One job at a time: load the instruction counter, run until done or watchdog, then idle the bus.
module rtc_bus_scheduler #(
   parameter int unsigned READ_PERIOD = 1000000,
   parameter int unsigned TIMEOUT     = 4096,
   parameter int unsigned GAP_CYCLES  = 4
) (
   input  logic       i_clk,
   input  logic       i_rst_n,
   input  logic       i_req_clear,
   input  logic       i_req_write,
   input  logic       i_listo_limpia,
   input  logic       i_listo_es,
   input  logic       i_listo_lee,
   output logic       o_en_es,
   output logic       o_up_es,
   output logic       o_ld_1,
   output logic       o_ld_2,
   output logic       o_en_lee,
   output logic [1:0] o_bus_sel,
   output logic       o_busy,
   output logic       o_ack_clear,
   output logic       o_ack_write,
   output logic       o_ack_read,
   output logic       o_err_timeout
);

   localparam int unsigned PeriodW = (READ_PERIOD > 1) ? $clog2(READ_PERIOD) : 1;
   localparam int unsigned WdogW   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam int unsigned GapW    = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
   localparam logic [PeriodW-1:0] PeriodLast = PeriodW'(READ_PERIOD - 1);
   localparam logic [WdogW-1:0]   WdogLast   = WdogW'(TIMEOUT - 1);
   localparam logic [GapW-1:0]    GapLast    = GapW'(GAP_CYCLES - 1);

   typedef enum logic [2:0] {StIdle, StLoad, StRun, StDone, StGap} state_e;
   typedef enum logic [1:0] {JobClear, JobWrite, JobRead} job_e;

   state_e             r_state;
   job_e               r_job;
   logic               r_pend_c, r_pend_w, r_pend_r;
   logic [PeriodW-1:0] r_period;
   logic [WdogW-1:0]   r_wdog;
   logic [GapW-1:0]    r_gap;
   logic               r_en_es, r_up_es, r_ld_1, r_ld_2, r_en_lee, r_busy;
   logic [1:0]         r_bus_sel;
   logic               r_ack_clear, r_ack_write, r_ack_read, r_err_timeout;

   logic w_wrap, w_done, w_timeout, w_finish;
   logic w_clr_c, w_clr_w, w_clr_r;

   assign w_wrap = (r_period == PeriodLast);

   // Only the done flag of the running job counts; the others are ignored.
   always_comb begin
      w_done = 1'b0;
      unique case (r_job)
         JobClear: w_done = i_listo_limpia;
         JobWrite: w_done = i_listo_es;
         JobRead:  w_done = i_listo_lee;
         default:  w_done = 1'b0;
      endcase
   end

   assign w_timeout = (r_state == StRun) && !w_done && (r_wdog == WdogLast);
   assign w_finish  = (r_state == StDone) || w_timeout;
   assign w_clr_c   = w_finish && (r_job == JobClear);
   assign w_clr_w   = w_finish && (r_job == JobWrite);
   assign w_clr_r   = w_finish && (r_job == JobRead);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state       <= StIdle;
         r_job         <= JobClear;
         r_pend_c      <= 1'b0;
         r_pend_w      <= 1'b0;
         r_pend_r      <= 1'b0;
         r_period      <= '0;
         r_wdog        <= '0;
         r_gap         <= '0;
         r_en_es       <= 1'b0;
         r_up_es       <= 1'b0;
         r_ld_1        <= 1'b0;
         r_ld_2        <= 1'b0;
         r_en_lee      <= 1'b0;
         r_busy        <= 1'b0;
         r_bus_sel     <= 2'b00;
         r_ack_clear   <= 1'b0;
         r_ack_write   <= 1'b0;
         r_ack_read    <= 1'b0;
         r_err_timeout <= 1'b0;
      end else begin
         // A new request in the clearing cycle keeps its flag set.
         r_pend_c <= i_req_clear | (r_pend_c & ~w_clr_c);
         r_pend_w <= i_req_write | (r_pend_w & ~w_clr_w);
         r_pend_r <= w_wrap | (r_pend_r & ~w_clr_r);
         r_period <= w_wrap ? '0 : r_period + PeriodW'(1);

         r_ld_1        <= 1'b0;
         r_ld_2        <= 1'b0;
         r_ack_clear   <= 1'b0;
         r_ack_write   <= 1'b0;
         r_ack_read    <= 1'b0;
         r_err_timeout <= 1'b0;

         unique case (r_state)
            StIdle: begin
               if (r_pend_c || r_pend_w || r_pend_r) begin
                  r_state <= StLoad;
                  r_busy  <= 1'b1;
                  if (r_pend_c) begin
                     r_job     <= JobClear;
                     r_ld_1    <= 1'b1;
                     r_bus_sel <= 2'b01;
                  end else if (r_pend_w) begin
                     r_job     <= JobWrite;
                     r_ld_2    <= 1'b1;
                     r_bus_sel <= 2'b01;
                  end else begin
                     r_job     <= JobRead;
                     r_bus_sel <= 2'b10;
                  end
               end
            end
            StLoad: begin
               r_state <= StRun;
               r_wdog  <= '0;
               if (r_job == JobRead) begin
                  r_en_lee <= 1'b1;
               end else begin
                  r_en_es <= 1'b1;
                  r_up_es <= 1'b1;
               end
            end
            StRun: begin
               if (w_done) begin
                  r_state     <= StDone;
                  r_en_es     <= 1'b0;
                  r_up_es     <= 1'b0;
                  r_en_lee    <= 1'b0;
                  r_ack_clear <= (r_job == JobClear);
                  r_ack_write <= (r_job == JobWrite);
                  r_ack_read  <= (r_job == JobRead);
               end else if (w_timeout) begin
                  r_state       <= StGap;
                  r_gap         <= '0;
                  r_en_es       <= 1'b0;
                  r_up_es       <= 1'b0;
                  r_en_lee      <= 1'b0;
                  r_bus_sel     <= 2'b00;
                  r_err_timeout <= 1'b1;
               end else begin
                  r_wdog <= r_wdog + WdogW'(1);
               end
            end
            StDone: begin
               r_state   <= StGap;
               r_gap     <= '0;
               r_bus_sel <= 2'b00;
            end
            StGap: begin
               if (r_gap == GapLast) begin
                  r_state <= StIdle;
                  r_busy  <= 1'b0;
               end else begin
                  r_gap <= r_gap + GapW'(1);
               end
            end
            default: r_state <= StIdle;
         endcase
      end
   end

   assign o_en_es       = r_en_es;
   assign o_up_es       = r_up_es;
   assign o_ld_1        = r_ld_1;
   assign o_ld_2        = r_ld_2;
   assign o_en_lee      = r_en_lee;
   assign o_bus_sel     = r_bus_sel;
   assign o_busy        = r_busy;
   assign o_ack_clear   = r_ack_clear;
   assign o_ack_write   = r_ack_write;
   assign o_ack_read    = r_ack_read;
   assign o_err_timeout = r_err_timeout;

endmodule
